// File: rtl/peri_timer_pkg.sv
// peri_timer shared definitions: register offsets and CTRL/STAT bit positions.
package peri_timer_pkg;

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CNT  = 2'd2;
    localparam logic [1:0] OFF_RLD  = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_ARL   = 1;
    localparam int CTRL_IEN   = 2;
    localparam int CTRL_PS_LO = 3;
    localparam int CTRL_PS_HI = 5;

    localparam int STAT_OVF = 0;

endpackage

// File: rtl/peri_timer_prescaler.sv
// peri_timer prescaler: free-running 7-bit divider producing a tick
// every 2^ps enabled cycles.
module peri_timer_prescaler (
    input  logic       clk_ip,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] ps,
    output logic       tick
);

    logic [6:0] pre;
    logic [6:0] mask;

    // Low ps bits set; ps=0 yields an empty mask, i.e. a tick every cycle.
    assign mask = ~(7'h7F << ps);
    assign tick = en && ((pre & mask) == mask);

    always_ff @(posedge clk_ip) begin
        if (reset) begin
            pre <= 7'd0;
        end else if (en) begin
            pre <= pre + 7'd1;
        end else begin
            pre <= 7'd0;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// peri_timer: 8-bit bus-mapped timer with overflow interrupt.
// Reload register and CTRL.ARL exist only with PERI_TIMER_RELOAD_EN defined.
module peri_timer
    import peri_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic       clk_ip,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic       irq_op
);

    logic       hit;
    logic [1:0] off;
    logic       wr_hit;
    logic       wr_ctrl;
    logic       wr_stat;
    logic       wr_cnt;
    logic       wr_rld;

    logic       en;
    logic       ien;
    logic       arl;
    logic       ovf;
    logic [2:0] ps;
    logic [7:0] cnt;
    logic [7:0] rld;

    logic       tick;
    logic       ovf_ev;

    assign hit     = (addr[7:2] == BASE_ADDR[7:2]);
    assign off     = addr[1:0];
    assign wr_hit  = wr_en && hit;
    assign wr_ctrl = wr_hit && (off == OFF_CTRL);
    assign wr_stat = wr_hit && (off == OFF_STAT);
    assign wr_cnt  = wr_hit && (off == OFF_CNT);
    assign wr_rld  = wr_hit && (off == OFF_RLD);

    peri_timer_prescaler u_pre (
        .clk_ip (clk_ip),
        .reset  (reset),
        .en     (en),
        .ps     (ps),
        .tick   (tick)
    );

    // A CPU write to CNT masks any overflow in the same cycle.
    assign ovf_ev = tick && (cnt == 8'hFF) && !wr_cnt;

    always_ff @(posedge clk_ip) begin
        if (reset) begin
            en  <= 1'b0;
            ien <= 1'b0;
            ps  <= 3'd0;
            ovf <= 1'b0;
            cnt <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                en  <= data_in[CTRL_EN];
                ien <= data_in[CTRL_IEN];
                ps  <= data_in[CTRL_PS_HI:CTRL_PS_LO];
            end
            if (ovf_ev && !arl) begin
                en <= 1'b0;
            end
            if (wr_stat && data_in[STAT_OVF]) begin
                ovf <= 1'b0;
            end
            if (ovf_ev) begin
                ovf <= 1'b1;
            end
            if (wr_cnt) begin
                cnt <= data_in;
            end else if (ovf_ev) begin
                cnt <= arl ? rld : 8'h00;
            end else if (tick) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef PERI_TIMER_RELOAD_EN
    always_ff @(posedge clk_ip) begin
        if (reset) begin
            arl <= 1'b0;
            rld <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                arl <= data_in[CTRL_ARL];
            end
            if (wr_rld) begin
                rld <= data_in;
            end
        end
    end
`else
    logic unused_wr_rld;
    assign unused_wr_rld = wr_rld;
    assign arl = 1'b0;
    assign rld = 8'h00;
`endif

    assign irq_op = ovf && ien;

    always_comb begin
        data_out = 8'h00;
        if (rd_en && hit) begin
            unique case (off)
                OFF_CTRL: data_out = {2'b00, ps, ien, arl, en};
                OFF_STAT: data_out = {7'd0, ovf};
                OFF_CNT:  data_out = cnt;
                OFF_RLD:  data_out = rld;
                default:  data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_peri_timer.sv
// Scoreboard bench for peri_timer at BASE_ADDR 8'h20; expectations
// track whether PERI_TIMER_RELOAD_EN is defined.
module tb_peri_timer;

`ifdef PERI_TIMER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    localparam logic [7:0] BA = 8'h20;
    localparam logic [7:0] A_CTRL = BA + 8'd0;
    localparam logic [7:0] A_STAT = BA + 8'd1;
    localparam logic [7:0] A_CNT  = BA + 8'd2;
    localparam logic [7:0] A_RLD  = BA + 8'd3;

    logic       clk_ip = 1'b0;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wr_en;
    logic       rd_en;
    logic       irq_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         is_irq;
        logic [7:0] exp;
    } sb_t;

    sb_t sbq[$];

    peri_timer #(.BASE_ADDR(BA)) dut (
        .clk_ip   (clk_ip),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .irq_op   (irq_op)
    );

    always #5 clk_ip = ~clk_ip;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_irq,
                        input logic [7:0] exp);
        sb_t e;
        e.tag    = tag;
        e.is_irq = is_irq;
        e.exp    = exp;
        sbq.push_back(e);
    endtask

    task automatic expect_irq(input string tag, input bit v);
        push(tag, 1'b1, {7'd0, v});
    endtask

    // One bus cycle: drive read, sample at negedge, drain the scoreboard.
    task automatic rd(input logic [7:0] a, input bit en,
                      input logic [7:0] exp, input string tag);
        sb_t e;
        addr  = a;
        rd_en = en;
        push(tag, 1'b0, exp);
        @(negedge clk_ip);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.is_irq)
                check(e.tag, {7'd0, irq_op}, e.exp);
            else
                check(e.tag, data_out, e.exp);
        end
        @(posedge clk_ip);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        wr_en   = 1'b1;
        @(posedge clk_ip);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        addr    = 8'h00;
        data_in = 8'h00;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        repeat (3) @(posedge clk_ip);
        #1;
        reset = 1'b0;

        // reset state
        expect_irq("rst_irq", 1'b0);
        rd(A_CTRL, 1'b1, 8'h00, "rst_ctrl");
        rd(A_STAT, 1'b1, 8'h00, "rst_stat");
        rd(A_CNT,  1'b1, 8'h00, "rst_cnt");
        rd(A_RLD,  1'b1, 8'h00, "rst_rld");
        rd(A_CTRL, 1'b0, 8'h00, "rd_off");

        // auto-reload overflow (one-shot without reload support)
        wr(A_RLD, 8'hF0);
        wr(A_CNT, 8'hFD);
        wr(A_CTRL, 8'h07);
        rd(A_CNT, 1'b1, 8'hFD, "ar_cnt0");
        rd(A_CNT, 1'b1, 8'hFE, "ar_cnt1");
        expect_irq("ar_irq_pre", 1'b0);
        rd(A_CNT, 1'b1, 8'hFF, "ar_cnt2");
        expect_irq("ar_irq_post", 1'b1);
        rd(A_CNT, 1'b1, RELOAD ? 8'hF0 : 8'h00, "ar_reload");
        rd(A_STAT, 1'b1, 8'h01, "ar_stat");
        rd(A_CTRL, 1'b1, RELOAD ? 8'h07 : 8'h04, "ar_ctrl");
        wr(A_STAT, 8'h01);
        expect_irq("ar_irq_clr", 1'b0);
        rd(A_STAT, 1'b1, 8'h00, "ar_stat_clr");
        wr(A_CTRL, 8'h00);

        // one-shot
        wr(A_CNT, 8'hFE);
        wr(A_CTRL, 8'h05);
        rd(A_CNT, 1'b1, 8'hFE, "os_cnt0");
        rd(A_CNT, 1'b1, 8'hFF, "os_cnt1");
        expect_irq("os_irq", 1'b1);
        rd(A_CNT, 1'b1, 8'h00, "os_cnt2");
        rd(A_CTRL, 1'b1, 8'h04, "os_ctrl");
        rd(A_STAT, 1'b1, 8'h01, "os_stat");
        rd(A_CNT, 1'b1, 8'h00, "os_hold");
        wr(A_STAT, 8'h01);
        wr(A_CTRL, 8'h00);

        // prescale PS=3: CNT steps every 8 cycles after the enable edge
        wr(A_CNT, 8'h00);
        wr(A_CTRL, 8'h19);
        for (int j = 0; j < 34; j++) begin
            rd(A_CNT, 1'b1, 8'(j / 8), $sformatf("ps_c%0d", j));
        end
        wr(A_CTRL, 8'h00);

        // CNT write on the overflow cycle wins
        wr(A_CNT, 8'hFE);
        wr(A_CTRL, 8'h01);
        rd(A_CNT, 1'b1, 8'hFE, "cw_pre");
        wr(A_CNT, 8'h10);
        rd(A_CNT, 1'b1, 8'h10, "cw_cnt");
        rd(A_STAT, 1'b1, 8'h00, "cw_stat");
        wr(A_CTRL, 8'h00);

        // STAT clear on the overflow cycle loses
        wr(A_CNT, 8'hFE);
        wr(A_CTRL, 8'h01);
        rd(A_CNT, 1'b1, 8'hFE, "sc_pre");
        wr(A_STAT, 8'h01);
        rd(A_STAT, 1'b1, 8'h01, "sc_stat");
        rd(A_CTRL, 1'b1, 8'h00, "sc_ctrl");
        wr(A_STAT, 8'h01);

        // EN set on a one-shot overflow cycle loses
        wr(A_CNT, 8'hFE);
        wr(A_CTRL, 8'h01);
        rd(A_CNT, 1'b1, 8'hFE, "es_pre");
        wr(A_CTRL, 8'h01);
        rd(A_CTRL, 1'b1, 8'h00, "es_ctrl");
        wr(A_STAT, 8'h01);

        // address decode
        wr(8'h1F, 8'hFF);
        wr(8'h24, 8'hFF);
        rd(A_CTRL, 1'b1, 8'h00, "dec_ctrl");
        rd(A_STAT, 1'b1, 8'h00, "dec_stat");
        rd(A_CNT,  1'b1, 8'h00, "dec_cnt");
        rd(A_RLD,  1'b1, RELOAD ? 8'hF0 : 8'h00, "dec_rld");
        wr(A_CNT, 8'h5A);
        rd(8'h1E, 1'b1, 8'h00, "dec_miss_lo");
        rd(8'h26, 1'b1, 8'h00, "dec_miss_hi");

        // reload configuration
        wr(A_RLD, 8'hAA);
        rd(A_RLD, 1'b1, RELOAD ? 8'hAA : 8'h00, "cfg_rld");
        wr(A_CTRL, 8'h03);
        rd(A_CTRL, 1'b1, RELOAD ? 8'h03 : 8'h01, "cfg_ctrl");
        wr(A_CTRL, 8'h00);

        // reset with an interrupt pending
        wr(A_CNT, 8'hFE);
        wr(A_CTRL, 8'h05);
        rd(A_CNT, 1'b1, 8'hFE, "mr_pre");
        expect_irq("mr_irq_pre", 1'b0);
        rd(A_CNT, 1'b1, 8'hFF, "mr_ff");
        expect_irq("mr_irq_set", 1'b1);
        rd(A_STAT, 1'b1, 8'h01, "mr_stat");
        reset = 1'b1;
        @(posedge clk_ip);
        #1;
        reset = 1'b0;
        expect_irq("mr_irq_rst", 1'b0);
        rd(A_STAT, 1'b1, 8'h00, "mr_stat_rst");
        rd(A_CTRL, 1'b1, 8'h00, "mr_ctrl_rst");
        rd(A_CNT,  1'b1, 8'h00, "mr_cnt_rst");
        rd(A_RLD,  1'b1, 8'h00, "mr_rld_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peri_timer.md
# peri_timer

8-bit programmable timer on the TRSQ8 peripheral bus. The CPU reads and writes four byte registers through the shared addr/data/wr_en/rd_en bus. The timer counts prescaled clock ticks and raises a level interrupt on overflow, which is routed to the CPU `irq_ip`. It lives beside the CPU in the core top level, at a configurable base address.

## Interface
- BASE_ADDR, 8'h10, bus address of register 0; the block occupies BASE_ADDR..BASE_ADDR+3 (BASE_ADDR[1:0] must be 0)
- clk_ip  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- addr  in  8  bus address from the CPU
- data_in  in  8  write data (CPU W register)
- data_out  out  8  read data to the CPU
- wr_en  in  1  store strobe, qualified by addr
- rd_en  in  1  load strobe, qualified by addr
- irq_op  out  1  level interrupt to the CPU `irq_ip`

## Operation
- hit = (addr[7:2] == BASE_ADDR[7:2]); off = addr[1:0].
- Registers:
  - CTRL (off 0): [0] EN; [1] ARL (auto-reload); [2] IEN; [5:3] PS (divide by 2^PS); [7:6] read 0.
  - STAT (off 1): [0] OVF; writing 1 clears it, writing 0 has no effect; [7:1] read 0.
  - CNT (off 2): counter, read/write.
  - RLD (off 3): reload value, read/write.
- Read: `data_out` = selected register when rd_en && hit, else 8'h00, so peripheral outputs can be ORed.
- Write: on posedge with wr_en && hit, `data_in` goes to the selected register.
- Prescaler:
  - 7-bit counter `pre`; held at 0 while EN=0.
  - tick = EN && (pre[PS-1:0] all ones); PS=0 gives a tick every cycle.
  - `pre` increments every enabled cycle.
- On tick with CNT != 8'hFF: CNT <= CNT+1.
- On tick with CNT == 8'hFF (overflow): OVF <= 1, then:
  - ARL=1: CNT <= RLD.
  - ARL=0 (one-shot): CNT <= 8'h00 and EN <= 0.
- irq_op = OVF && IEN, combinational from registers.
- Simultaneous events:
  - Bus write to CNT and tick in the same cycle: the write wins; no overflow is flagged that cycle.
  - Write-1-clear of OVF and overflow in the same cycle: the set wins (OVF stays 1).
  - Bus write to CTRL clearing EN and one-shot overflow in the same cycle: the result is EN=0 either way.
  - Bus write to CTRL setting EN in the same cycle as a one-shot overflow: EN=0 (overflow wins).
- Reads have no side effects.

## Timing
- Reset values: CTRL=0, STAT=0, CNT=0, RLD=0, pre=0, irq_op=0. data_out=0 while rd_en=0.
- Read latency: 0 cycles, combinational from addr/rd_en. The CPU samples data on negedge in the same cycle.
- Write latency: the register updates on the posedge during wr_en and is visible to reads in the next cycle.
- The first tick occurs 2^PS cycles after the EN=1 write edge.
- Overflow to irq_op: irq_op rises in the cycle after the overflow edge and stays high until OVF is cleared or IEN=0.
- Reset asserted mid-count returns all state to reset values on the next posedge. A pending irq_op drops in the same cycle.

## Configuration
- PERI_TIMER_RELOAD_EN defined: RLD register and the CTRL.ARL bit are implemented as described above.
- Not defined:
  - RLD reads 8'h00 and writes to it are ignored.
  - ARL reads 0 and the timer always behaves as one-shot.
  - Overflow loads 8'h00 and clears EN.

## Structure
- Package `peri_timer_pkg`: register offsets (OFF_CTRL=0, OFF_STAT=1, OFF_CNT=2, OFF_RLD=3) and CTRL/STAT bit positions.
- Sub-module `peri_timer_prescaler`:
  - inputs: clk_ip, reset, en, ps[2:0]
  - output: tick
  - contains `pre`
- The top level holds the register file, the counter/overflow logic and the bus decode.

## Test plan
- Reset, then read all four offsets -> 8'h00 each; irq_op=0; read with rd_en=0 -> data_out=0.
- Write RLD=8'hF0, CNT=8'hFD, CTRL=8'h07 (EN, ARL, IEN, PS=0) -> overflow on 3rd tick:
  - CNT=8'hF0
  - STAT=1
  - irq_op=1 one cycle after the overflow edge
  - write STAT=1 -> irq_op=0
- One-shot: CNT=8'hFE, CTRL=8'h05 -> after 2 ticks, CNT=0, CTRL.EN=0, OVF=1; CNT then stays 0.
- Prescale: PS=3, CNT=0 -> CNT=1 exactly 8 cycles after the enable write, CNT=4 after 32 cycles.
- Collisions:
  - CNT write of 8'h10 on the overflow cycle -> CNT=8'h10, OVF=0.
  - STAT clear on the overflow cycle -> OVF=1.
- Address decode: with BASE_ADDR=8'h20, writes to 8'h1F/8'h24 leave all registers unchanged.
- Without PERI_TIMER_RELOAD_EN: RLD write of 8'hAA then read -> 8'h00; CTRL write of 8'h03 then read -> 8'h01.
